// File: rtl/rf_write_arbiter_pkg.sv
// rf_write_arbiter_pkg: shared core widths, requester indices and register mask helper
package rf_write_arbiter_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN = 32;
  localparam int NUM_REGS = 32;
  localparam int REQ_WB = 0;
  localparam int REQ_LL = 1;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0] xlen_t;
  typedef logic [NUM_REGS-1:0] reg_mask_t;
  function automatic reg_mask_t reg_bit(input reg_addr_t r);
    return reg_mask_t'(1) << r;
  endfunction
endpackage

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: writeback requesters, long-latency issue, decode lookup and RF write port
interface rf_write_arbiter_if;
  import rf_write_arbiter_pkg::*;
  logic wb_valid;
  reg_addr_t wb_rd;
  xlen_t wb_data;
  logic wb_ready;
  logic ll_valid;
  reg_addr_t ll_rd;
  xlen_t ll_data;
  logic ll_ready;
  logic iss_valid;
  reg_addr_t iss_rd;
  reg_addr_t rs1;
  reg_addr_t rs2;
  logic stall;
  logic rf_we;
  reg_addr_t rf_waddr;
  xlen_t rf_wdata;
  modport slave (
    input wb_valid, wb_rd, wb_data, ll_valid, ll_rd, ll_data, iss_valid, iss_rd, rs1, rs2,
    output wb_ready, ll_ready, stall, rf_we, rf_waddr, rf_wdata
  );
  modport master (
    output wb_valid, wb_rd, wb_data, ll_valid, ll_rd, ll_data, iss_valid, iss_rd, rs1, rs2,
    input wb_ready, ll_ready, stall, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/rf_write_arbiter_scoreboard.sv
// rf_write_arbiter_scoreboard: pending long-latency write bits with two decode lookup ports
module rf_write_arbiter_scoreboard
  import rf_write_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      set_i,
  input  reg_addr_t set_rd_i,
  input  logic      clr_i,
  input  reg_addr_t clr_rd_i,
  input  reg_addr_t rs1_i,
  input  reg_addr_t rs2_i,
  output logic      stall_o
);
  reg_mask_t pend_q, pend_d;
  // clear is applied before set so a reissue to the same register keeps it owed; bit 0 never sticks
  assign pend_d = ((pend_q & ~(clr_i ? reg_bit(clr_rd_i) : '0)) | (set_i ? reg_bit(set_rd_i) : '0))
                  & ~reg_mask_t'(1);
  assign stall_o = pend_q[rs1_i] | pend_q[rs2_i];
  always_ff @(posedge clk or negedge rst)
    if (!rst) pend_q <= '0;
    else pend_q <= pend_d;
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: fixed-priority RF write port sharing with starvation guard for the long-latency path
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input logic clk,
  input logic rst,
  rf_write_arbiter_if.slave bus
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_q, starve_d;
  logic grant, rf_we_q;
  reg_addr_t g_rd, rf_waddr_q;
  xlen_t g_data, rf_wdata_q;
  assign bus.ll_ready = bus.ll_valid & (~bus.wb_valid | (starve_q == LIMIT));
  assign bus.wb_ready = bus.wb_valid & ~bus.ll_ready;
  assign grant = bus.wb_ready | bus.ll_ready;
  assign g_rd = bus.ll_ready ? bus.ll_rd : bus.wb_rd;
  assign g_data = bus.ll_ready ? bus.ll_data : bus.wb_data;
  assign starve_d = bus.ll_ready ? '0
                  : (bus.ll_valid && starve_q != LIMIT) ? starve_q + 4'd1 : starve_q;
  // x0 writes still win the port and update address/data, but never enable the write
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      starve_q <= '0;
      rf_we_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      starve_q <= starve_d;
      rf_we_q <= grant && g_rd != '0;
      if (grant) begin
        rf_waddr_q <= g_rd;
        rf_wdata_q <= g_data;
      end
    end
  assign bus.rf_we = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  rf_write_arbiter_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_i    (bus.iss_valid),
    .set_rd_i (bus.iss_rd),
    .clr_i    (bus.ll_ready),
    .clr_rd_i (bus.ll_rd),
    .rs1_i    (bus.rs1),
    .rs2_i    (bus.rs2),
    .stall_o  (bus.stall)
  );
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed stimulus with a reference model feeding an expected-write queue
module tb_rf_write_arbiter;
  localparam int LIMIT = 3;
  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  int m_starve = 0;
  logic [31:0] m_pend = '0;
  logic [4:0] last_a = '0;
  logic [31:0] last_d = '0;
  logic last_wb, last_ll, obs_ll;
  logic [5:0] pat;
  wr_t q[$];
  rf_write_arbiter_if bus ();
  rf_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    bus.wb_valid = 0; bus.ll_valid = 0; bus.iss_valid = 0;
  endtask
  task automatic tick();
    logic ew, el, es;
    wr_t w;
    #1;
    el = bus.ll_valid && (!bus.wb_valid || m_starve == LIMIT);
    ew = bus.wb_valid && !el;
    es = (bus.rs1 != 0 && m_pend[bus.rs1]) || (bus.rs2 != 0 && m_pend[bus.rs2]);
    obs_ll = bus.ll_ready;
    chk("wb_ready", 32'(bus.wb_ready), 32'(ew));
    chk("ll_ready", 32'(bus.ll_ready), 32'(el));
    chk("stall", 32'(bus.stall), 32'(es));
    if (ew || el) begin
      last_a = el ? bus.ll_rd : bus.wb_rd;
      last_d = el ? bus.ll_data : bus.wb_data;
    end
    q.push_back('{we: (ew || el) && last_a != 0, a: last_a, d: last_d});
    m_starve = el ? 0 : (bus.ll_valid && m_starve < LIMIT) ? m_starve + 1 : m_starve;
    if (el) m_pend[bus.ll_rd] = 1'b0;
    if (bus.iss_valid && bus.iss_rd != 0) m_pend[bus.iss_rd] = 1'b1;
    last_wb = ew;
    last_ll = el;
    @(posedge clk);
    #1;
    w = q.pop_front();
    chk("rf_we", 32'(bus.rf_we), 32'(w.we));
    chk("rf_waddr", 32'(bus.rf_waddr), 32'(w.a));
    chk("rf_wdata", bus.rf_wdata, w.d);
  endtask
  initial begin
    idle();
    bus.wb_rd = 0; bus.wb_data = 0; bus.ll_rd = 0; bus.ll_data = 0;
    bus.iss_rd = 0; bus.rs1 = 0; bus.rs2 = 0;
    #2;
    chk("reset_we", 32'(bus.rf_we), 32'd0);
    chk("reset_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("reset_wdata", bus.rf_wdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    // single pipeline write
    bus.wb_valid = 1; bus.wb_rd = 5; bus.wb_data = 32'h0000000A;
    tick();
    idle();
    tick();
    // contention: long-latency path must win on the fourth cycle
    bus.wb_valid = 1; bus.wb_rd = 1; bus.wb_data = 32'h100;
    bus.ll_valid = 1; bus.ll_rd = 2; bus.ll_data = 32'h200;
    for (int i = 0; i < 6; i++) begin
      tick();
      pat[i] = obs_ll;
      if (last_wb) bus.wb_data = bus.wb_data + 1;
      if (last_ll) bus.ll_data = bus.ll_data + 1;
    end
    chk("starve_pattern", 32'(pat), 32'b001000);
    idle();
    tick();
    // long-latency issue to x9 stalls decode until its return is written
    bus.iss_valid = 1; bus.iss_rd = 9; bus.rs1 = 9;
    tick();
    bus.iss_valid = 0;
    tick();
    chk("stall_x9_pending", 32'(bus.stall), 32'd1);
    tick();
    bus.ll_valid = 1; bus.ll_rd = 9; bus.ll_data = 32'h99;
    tick();
    idle();
    tick();
    chk("stall_x9_cleared", 32'(bus.stall), 32'd0);
    // reissue to x7 in the same cycle its old result returns
    bus.rs1 = 0; bus.rs2 = 7;
    bus.iss_valid = 1; bus.iss_rd = 7;
    tick();
    bus.ll_valid = 1; bus.ll_rd = 7; bus.ll_data = 32'h77;
    tick();
    idle();
    tick();
    chk("stall_x7_persists", 32'(bus.stall), 32'd1);
    bus.ll_valid = 1;
    tick();
    idle();
    bus.rs2 = 0;
    tick();
    // write to x0
    bus.wb_valid = 1; bus.wb_rd = 0; bus.wb_data = 32'hDEADBEEF;
    tick();
    chk("x0_no_we", 32'(bus.rf_we), 32'd0);
    idle();
    tick();
    // async reset with x3 pending and a write request outstanding
    bus.iss_valid = 1; bus.iss_rd = 3;
    bus.wb_valid = 1; bus.wb_rd = 6; bus.wb_data = 32'h66;
    tick();
    bus.iss_valid = 0; bus.rs1 = 3;
    bus.wb_rd = 4; bus.wb_data = 32'h44;
    #1;
    chk("pre_reset_stall", 32'(bus.stall), 32'd1);
    chk("pre_reset_we", 32'(bus.rf_we), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_we", 32'(bus.rf_we), 32'd0);
    chk("rst_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("rst_wdata", bus.rf_wdata, 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_wb_ready", 32'(bus.wb_ready), 32'd1);
    m_pend = '0; m_starve = 0; last_a = '0; last_d = '0;
    @(negedge clk);
    idle();
    rst = 1'b1;
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
